// File: rtl/s2p_pkg.sv
// Shared types for the serial-to-parallel receiver: FSM state encoding and default width.
package s2p_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/s2p_hold_reg.sv
// One-entry output holding register with valid/ready handshake and a load-when-full drop pulse.
module s2p_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             drop
);

  // Handshake: a word transfers on any edge where valid & ready; data is stable
  // while valid=1. A load that coincides with a transfer refills without a bubble;
  // a load while full and not being drained is dropped and reported via drop.
  logic accept;

  assign accept = load & (~valid | ready);
  assign drop   = load & valid & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (accept) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// MSB-first framed serial receiver: shifts qualified bits into WIDTH-bit words and
// hands them to a holding register, with sticky overrun and framing-error flags.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clear_flags,
  output state_t           state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             word_done;
  logic             frame_evt;
  logic             drop;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      sr    <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    count_nxt = count;
    word_done = 1'b0;
    frame_evt = 1'b0;
    if (bit_valid) begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            sr_nxt    = {sr[WIDTH-2:0], serial_in};
            count_nxt = CW'(1);
            state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr_nxt = {sr[WIDTH-2:0], serial_in};
          if (frame_start) begin
            // Restart: older bits left in sr are shifted out before this word completes.
            frame_evt = 1'b1;
            count_nxt = CW'(1);
          end else if (count == LAST_IDX) begin
            word_done = 1'b1;
            count_nxt = '0;
            state_nxt = S_IDLE;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // The completed word is loaded straight from the shift path, so it is visible
  // in the cycle right after its last bit.
  s2p_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (word_done),
    .load_data (sr_nxt),
    .ready     (data_ready),
    .data      (data_out),
    .valid     (data_valid),
    .drop      (drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= drop | (overrun & ~clear_flags);
      frame_err <= frame_evt | (frame_err & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: hand-computed words, stalls, overrun,
// framing restart, mid-word reset and stray bits while idle.
module tb_serial_to_parallel;
  import s2p_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ready = 1'b1;
  logic         overrun;
  logic         frame_err;
  logic         clear_flags = 1'b0;
  state_t       state_dbg;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_to_parallel #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .serial_in   (serial_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .clear_flags (clear_flags),
    .state_dbg   (state_dbg)
  );

  // Present inputs for one cycle; return 1ns after the edge that samples them.
  task automatic step(input logic bv, input logic fs, input logic si);
    bit_valid   = bv;
    frame_start = fs;
    serial_in   = si;
    @(posedge clk);
    #1;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    serial_in   = 1'b0;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Send the first n bits of w MSB-first on consecutive cycles, frame_start on the first.
  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, i == 0, w[W-1-i]);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;
    idle_step();

    // 1: 0xA5 on consecutive cycles, consumer always ready
    send_bits(8'hA5, 7);
    check("t1_dv_before_last", 32'(data_valid), 32'h0);
    step(1'b1, 1'b0, 1'b1);
    check("t1_dv", 32'(data_valid), 32'h1);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_overrun", 32'(overrun), 32'h0);
    check("t1_frame_err", 32'(frame_err), 32'h0);
    idle_step();
    check("t1_dv_pulse", 32'(data_valid), 32'h0);

    // 2: 0x3C = 0011_1100 with 2-cycle stalls after bits 3 and 6
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    idle_step();
    idle_step();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    idle_step();
    idle_step();
    step(1'b1, 1'b0, 1'b0);
    check("t2_dv_before_last", 32'(data_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    check("t2_dv", 32'(data_valid), 32'h1);
    check("t2_data", 32'(data_out), 32'h3C);
    idle_step();
    check("t2_dv_pulse", 32'(data_valid), 32'h0);

    // 3: 0x11 then 0x22 back-to-back with consumer stalled
    data_ready = 1'b0;
    send_bits(8'h11, 8);
    check("t3_dv_first", 32'(data_valid), 32'h1);
    check("t3_data_first", 32'(data_out), 32'h11);
    check("t3_no_overrun_yet", 32'(overrun), 32'h0);
    send_bits(8'h22, 8);
    check("t3_dv_held", 32'(data_valid), 32'h1);
    check("t3_data_kept", 32'(data_out), 32'h11);
    check("t3_overrun", 32'(overrun), 32'h1);
    data_ready = 1'b1;
    idle_step();
    check("t3_dv_after_xfer", 32'(data_valid), 32'h0);
    check("t3_overrun_sticky", 32'(overrun), 32'h1);
    clear_flags = 1'b1;
    idle_step();
    clear_flags = 1'b0;
    check("t3_overrun_cleared", 32'(overrun), 32'h0);

    // 4: 5 bits, then a new frame 0xF0 restarts mid-word
    send_bits(8'hFF, 5);
    check("t4_no_frame_err_yet", 32'(frame_err), 32'h0);
    step(1'b1, 1'b1, 1'b1);
    check("t4_frame_err", 32'(frame_err), 32'h1);
    check("t4_dv_not_early", 32'(data_valid), 32'h0);
    for (int i = 1; i < W; i++) step(1'b1, 1'b0, (i < 4) ? 1'b1 : 1'b0);
    check("t4_dv", 32'(data_valid), 32'h1);
    check("t4_data", 32'(data_out), 32'hF0);
    clear_flags = 1'b1;
    idle_step();
    clear_flags = 1'b0;
    check("t4_frame_err_cleared", 32'(frame_err), 32'h0);

    // 4b: clear_flags coinciding with a framing error leaves the flag set
    send_bits(8'h00, 3);
    clear_flags = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    clear_flags = 1'b0;
    check("t4b_set_wins", 32'(frame_err), 32'h1);
    for (int i = 1; i < W; i++) step(1'b1, 1'b0, ((8'h5A >> (W - 1 - i)) & 8'h1) != 0);
    check("t4b_data", 32'(data_out), 32'h5A);
    clear_flags = 1'b1;
    idle_step();
    clear_flags = 1'b0;

    // 5: asynchronous reset after 4 bits of 0xFF, with a word pending
    data_ready = 1'b0;
    send_bits(8'h77, 8);
    send_bits(8'hFF, 4);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_data", 32'(data_out), 32'h0);
    check("t5_rst_dv", 32'(data_valid), 32'h0);
    check("t5_rst_flags", 32'({overrun, frame_err}), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_ready = 1'b1;
    send_bits(8'h81, 8);
    check("t5_dv", 32'(data_valid), 32'h1);
    check("t5_data", 32'(data_out), 32'h81);
    check("t5_flags", 32'({overrun, frame_err}), 32'h0);
    idle_step();

    // 6: valid bits without frame_start while idle are dropped
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'(i));
    check("t6_dv", 32'(data_valid), 32'h0);
    check("t6_state", 32'(state_dbg), 32'(S_IDLE));
    check("t6_flags", 32'({overrun, frame_err}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
